// File: rtl/zcip_pkg.sv
// Shared constants, FSM state type and helpers for the ZCIP encoder.
package zcip_pkg;

   localparam int MAG_W     = 7;
   localparam int COL_IDX_W = 3;
   localparam int WEIGHT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      COL
   } state_t;

   function automatic logic [COL_IDX_W-1:0] popcount7(input logic [MAG_W-1:0] m);
      logic [COL_IDX_W-1:0] n;
      n = '0;
      for (int k = 0; k < MAG_W; k++) begin
         n = n + COL_IDX_W'(m[k]);
      end
      return n;
   endfunction

   // Saturates at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? '1 : s[31:0];
   endfunction

endpackage

// File: rtl/zcip_lsb_pick.sv
// Lowest-set-bit selector over a 7-bit column mask: index, one-hot clear mask,
// and a flag telling whether that bit is the only one set.
module zcip_lsb_pick
   import zcip_pkg::*;
(
   input  logic [MAG_W-1:0]     mask,
   output logic [COL_IDX_W-1:0] idx,
   output logic [MAG_W-1:0]     clear,
   output logic                 is_single
);

   always_comb begin
      idx = '0;
      // Walking downward leaves the lowest set position in idx.
      for (int k = MAG_W - 1; k >= 0; k--) begin
         if (mask[k]) begin
            idx = COL_IDX_W'(k);
         end
      end
      clear     = mask & (~mask + MAG_W'(1));
      is_single = (mask != '0) && ((mask & (mask - MAG_W'(1))) == '0);
   end

endmodule

// File: rtl/zcip_encoder.sv
// ZCIP encoder: emits a header beat then only the non-zero magnitude bit-columns
// of each weight group, in ascending column order. Optional counters: ZCIP_ENC_STATS_EN.
module zcip_encoder
   import zcip_pkg::*;
#(
   parameter int GROUP = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [GROUP*WEIGHT_W-1:0] in_weights,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_hdr,
   output logic [MAG_W-1:0]          out_index_vector,
   output logic [GROUP-1:0]          out_signs,
   output logic [GROUP-1:0]          out_col_data,
   output logic [COL_IDX_W-1:0]      out_col_idx,
   output logic                      out_last
`ifdef ZCIP_ENC_STATS_EN
   ,
   output logic [31:0]               stat_groups,
   output logic [31:0]               stat_cols_skipped,
   output logic [31:0]               stat_cols_sent
`endif
);

   state_t           state;
   logic [MAG_W-1:0] mag_q [GROUP];
   // Columns of the current group not yet presented on the output.
   logic [MAG_W-1:0] pending;

   logic [MAG_W-1:0]     idx_new;
   logic [GROUP-1:0]     signs_new;
   logic [COL_IDX_W-1:0] nxt_idx;
   logic [MAG_W-1:0]     nxt_clr;
   logic                 nxt_single;
   logic [GROUP-1:0]     nxt_col;
   logic                 accept;
   logic                 finish;

   // Handshake: a beat transfers on a cycle with out_valid && out_ready, a group
   // on in_valid && in_ready; an unaccepted beat is held unchanged.
   assign finish   = out_valid && out_ready && out_last;
   assign in_ready = (state == IDLE) || finish;
   assign accept   = in_valid && in_ready;

   always_comb begin
      idx_new   = '0;
      signs_new = '0;
      for (int j = 0; j < GROUP; j++) begin
         idx_new      = idx_new | in_weights[j*WEIGHT_W +: MAG_W];
         // Negative zero is encoded as positive zero.
         signs_new[j] = in_weights[j*WEIGHT_W + MAG_W] &&
                        (in_weights[j*WEIGHT_W +: MAG_W] != '0);
      end
   end

   zcip_lsb_pick u_pick (
      .mask      (pending),
      .idx       (nxt_idx),
      .clear     (nxt_clr),
      .is_single (nxt_single)
   );

   always_comb begin
      nxt_col = '0;
      for (int j = 0; j < GROUP; j++) begin
         nxt_col[j] = mag_q[j][nxt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         pending          <= '0;
         for (int j = 0; j < GROUP; j++) mag_q[j] <= '0;
         out_valid        <= 1'b0;
         out_hdr          <= 1'b0;
         out_index_vector <= '0;
         out_signs        <= '0;
         out_col_data     <= '0;
         out_col_idx      <= '0;
         out_last         <= 1'b0;
      end else if (accept) begin
         for (int j = 0; j < GROUP; j++) mag_q[j] <= in_weights[j*WEIGHT_W +: MAG_W];
         pending          <= idx_new;
         state            <= HDR;
         out_valid        <= 1'b1;
         out_hdr          <= 1'b1;
         out_index_vector <= idx_new;
         out_signs        <= signs_new;
         out_col_data     <= '0;
         out_col_idx      <= '0;
         out_last         <= (idx_new == '0);
      end else if (finish) begin
         state            <= IDLE;
         pending          <= '0;
         out_valid        <= 1'b0;
         out_hdr          <= 1'b0;
         out_index_vector <= '0;
         out_signs        <= '0;
         out_col_data     <= '0;
         out_col_idx      <= '0;
         out_last         <= 1'b0;
      end else if (state != IDLE && out_ready) begin
         // Not the last beat, so at least one column remains in pending.
         state            <= COL;
         pending          <= pending & ~nxt_clr;
         out_hdr          <= 1'b0;
         out_index_vector <= '0;
         out_signs        <= '0;
         out_col_data     <= nxt_col;
         out_col_idx      <= nxt_idx;
         out_last         <= nxt_single;
      end
   end

`ifdef ZCIP_ENC_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_groups       <= '0;
         stat_cols_skipped <= '0;
         stat_cols_sent    <= '0;
      end else begin
         if (accept) begin
            stat_groups       <= sat_add32(stat_groups, 32'd1);
            stat_cols_skipped <= sat_add32(stat_cols_skipped,
                                           32'(3'd7 - popcount7(idx_new)));
         end
         if (out_valid && out_ready && !out_hdr) begin
            stat_cols_sent <= sat_add32(stat_cols_sent, 32'd1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_zcip_encoder.sv
// Bench for zcip_encoder: directed cases plus random groups checked against a
// beat-list model of the encoding rules. Build with ZCIP_ENC_STATS_EN to cover counters.
module tb_zcip_encoder;

   localparam int G  = 16;
   localparam int BW = 1 + 7 + G + G + 3 + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [G*8-1:0]   in_weights;
   logic             out_valid;
   logic             out_ready;
   logic             out_hdr;
   logic [6:0]       out_index_vector;
   logic [G-1:0]     out_signs;
   logic [G-1:0]     out_col_data;
   logic [2:0]       out_col_idx;
   logic             out_last;
`ifdef ZCIP_ENC_STATS_EN
   logic [31:0]      stat_groups;
   logic [31:0]      stat_cols_skipped;
   logic [31:0]      stat_cols_sent;
`endif

   int checks   = 0;
   int failures = 0;
   int rdy_mode = 0;
   logic [BW-1:0] exp_q[$];
   int m_groups = 0;
   int m_skipped = 0;
   int m_sent = 0;

   zcip_encoder #(.GROUP(G)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_weights       (in_weights),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_hdr          (out_hdr),
      .out_index_vector (out_index_vector),
      .out_signs        (out_signs),
      .out_col_data     (out_col_data),
      .out_col_idx      (out_col_idx),
      .out_last         (out_last)
`ifdef ZCIP_ENC_STATS_EN
      ,
      .stat_groups       (stat_groups),
      .stat_cols_skipped (stat_cols_skipped),
      .stat_cols_sent    (stat_cols_sent)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk(input logic hdr, input logic [6:0] iv,
                                        input logic [G-1:0] sg, input logic [G-1:0] cd,
                                        input logic [2:0] ci, input logic last);
      return {hdr, iv, sg, cd, ci, last};
   endfunction

   // Reference: header, then one beat per non-zero column in ascending order.
   task automatic push_group(input logic [G*8-1:0] w);
      int mag[G];
      logic [6:0] iv;
      logic [G-1:0] sg;
      logic [G-1:0] cd;
      int n, sent;
      iv = '0;
      sg = '0;
      for (int j = 0; j < G; j++) begin
         mag[j] = int'(w[j*8 +: 7]);
         if (w[j*8+7] == 1'b1 && mag[j] != 0) sg[j] = 1'b1;
      end
      n = 0;
      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < G; j++) if (((mag[j] >> k) & 1) == 1) iv[k] = 1'b1;
         if (iv[k]) n++;
      end
      exp_q.push_back(mk(1'b1, iv, sg, '0, 3'd0, n == 0));
      sent = 0;
      for (int k = 0; k < 7; k++) begin
         if (iv[k]) begin
            for (int j = 0; j < G; j++) cd[j] = ((mag[j] >> k) & 1) == 1;
            sent++;
            exp_q.push_back(mk(1'b0, 7'd0, '0, cd, 3'(k), sent == n));
         end
      end
      m_groups++;
      m_skipped += 7 - n;
      m_sent    += n;
   endtask

   // Offer a group; returns whether it was taken during a last-beat handshake.
   task automatic send(input logic [G*8-1:0] w, input bit use_model, output logic during_last);
      int n;
      during_last = 1'b0;
      in_weights  = w;
      in_valid    = 1'b1;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
      end else begin
         during_last = out_valid && out_ready && out_last;
         if (use_model) push_group(w);
         @(posedge clk);
         #1;
         in_valid   = 1'b0;
         in_weights = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chk("hdr_latency", 64'({out_valid, out_hdr}), 64'd3);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   // out_ready driver: 0 = always ready, 1 = toggle, 2 = random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the model on each handshake and checks stalled beats stay put.
   logic [BW-1:0] held_beat;
   bit            held = 0;
   initial begin
      logic [BW-1:0] cur;
      forever begin
         @(negedge clk);
         cur = mk(out_hdr, out_index_vector, out_signs, out_col_data, out_col_idx, out_last);
         if (rst) begin
            held = 0;
         end else begin
            if (held) chk("stall_hold", 64'(cur), 64'(held_beat));
            if (out_valid && out_ready) begin
               chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) chk("beat", 64'(cur), 64'(exp_q.pop_front()));
               held = 0;
            end else if (out_valid) begin
               held      = 1;
               held_beat = cur;
            end else begin
               held = 0;
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_state"}, 64'(dut.state), 64'(zcip_pkg::IDLE));
      chk({tag, "_data"}, 64'({out_hdr, out_last, out_index_vector, out_signs,
                                out_col_data, out_col_idx}), 64'd0);
`ifdef ZCIP_ENC_STATS_EN
      chk({tag, "_stats"}, 64'(stat_groups | stat_cols_skipped | stat_cols_sent), 64'd0);
`endif
   endtask

   initial begin
      logic [G*8-1:0] w1, w_zero, w_negz, w_full, w;
      logic dl;
      int n;
      logic [6:0] cm;

      w1 = '0;
      w1[7:0]  = 8'h05;
      w1[15:8] = 8'h84;
      w_zero = '0;
      w_negz = {G{8'h80}};
      w_full = {G{8'h7F}};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_weights = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // Hand-derived beats for the small two-weight group.
      rdy_mode = 0;
      exp_q.push_back(mk(1'b1, 7'h05, 16'h0002, 16'h0000, 3'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 7'h00, 16'h0000, 16'h0001, 3'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 7'h00, 16'h0000, 16'h0003, 3'd2, 1'b1));
      m_groups = 1; m_skipped = 5; m_sent = 2;
      send(w1, 1'b0, dl);
      drain();

      send(w_zero, 1'b1, dl);
      drain();
      send(w_negz, 1'b1, dl);
      drain();
      send(w_full, 1'b1, dl);
      chk("full_beats", 64'(exp_q.size()), 64'd7);
      drain();

      rdy_mode = 1;
      send(w1, 1'b1, dl);
      drain();

      rdy_mode = 0;
      send(w1, 1'b1, dl);
      send(w_full, 1'b1, dl);
      chk("b2b_in_ready_on_last", 64'(dl), 64'd1);
      drain();

      // Reset in the middle of the column beats.
      send(w_full, 1'b1, dl);
      n = 0;
      while (!(out_valid && !out_hdr && out_col_idx >= 3'd2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_col", 64'(out_valid && !out_hdr), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_groups = 0; m_skipped = 0; m_sent = 0;
      @(negedge clk);
      check_idle("mid_reset");
      send(w1, 1'b1, dl);
      drain();

      // Random groups with a random column mask per group.
      rdy_mode = 2;
      for (int g = 0; g < 40; g++) begin
         cm = 7'($urandom);
         if (g % 8 == 0) cm = '0;
         w = '0;
         for (int j = 0; j < G; j++) begin
            w[j*8 +: 7] = 7'($urandom) & cm;
            w[j*8+7]    = 1'($urandom);
         end
         send(w, 1'b1, dl);
      end
      rdy_mode = 0;
      drain();
      chk("final_idle", 64'({out_valid, in_ready}), 64'd1);
`ifdef ZCIP_ENC_STATS_EN
      chk("stat_groups", 64'(stat_groups), 64'(m_groups));
      chk("stat_cols_skipped", 64'(stat_cols_skipped), 64'(m_skipped));
      chk("stat_cols_sent", 64'(stat_cols_sent), 64'(m_sent));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
